axi_lite_regfile: RTL and testbench
===================================

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the AXI4-Lite address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data width; legal values are 32 or 64.
REQ-003 The block SHALL have parameter NUM_REGS, default 8, meaning the register count; legal range is 1..256.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port s_awaddr/s_awvalid/s_awready, in/in/out, ADDR_WIDTH/1/1: the write address channel.
REQ-007 The block SHALL have port s_wdata/s_wstrb/s_wvalid/s_wready, in/in/in/out, DATA_WIDTH/DATA_WIDTH/8/1/1: the write data channel.
REQ-008 The block SHALL have port s_bresp/s_bvalid/s_bready, out/out/in, 2/1/1: the write response channel.
REQ-009 The block SHALL have port s_araddr/s_arvalid/s_arready, in/in/out, ADDR_WIDTH/1/1: the read address channel.
REQ-010 The block SHALL have port s_rdata/s_rresp/s_rvalid/s_rready, out/out/out/in, DATA_WIDTH/2/1/1: the read data channel.
REQ-011 The block SHALL have port regs_o, output, NUM_REGS*DATA_WIDTH: the flattened register contents, with register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 The block SHALL have port wr_pulse_o, output, NUM_REGS: bit i is high for one cycle when register i is written.

Function
REQ-013 Decode SHALL use index = addr >> log2(DATA_WIDTH/8); the low byte-offset bits are ignored and the access is in range iff index < NUM_REGS.
REQ-014 The write path SHALL accept AW and W independently, in any order or in the same cycle, latching each into a holding register.
REQ-015 s_awready SHALL be high iff no AW is latched and s_bvalid is low; s_wready SHALL be high iff no W is latched and s_bvalid is low.
REQ-016 On the rising edge that completes the second of the AW/W handshakes, the block SHALL:
- update the target register per s_wstrb byte lanes;
- pulse the matching wr_pulse_o bit;
- set s_bvalid.
REQ-017 s_bvalid and s_bresp SHALL hold stable until s_bready is high; both holding registers SHALL clear on the B handshake.
REQ-018 Write FSM states SHALL be W_IDLE, W_GOT_AW, W_GOT_W and W_RESP, with W_RESP returning to W_IDLE on the B handshake.
REQ-019 s_arready SHALL be high iff s_rvalid is low (states R_IDLE and R_DATA).
REQ-020 On an AR handshake, s_rdata, s_rresp and s_rvalid SHALL be registered on that edge, giving a read latency of one cycle.
REQ-021 s_rdata and s_rresp SHALL hold stable until s_rready is high.
REQ-022 When a read and a write complete to the same register on the same edge, the read SHALL return the pre-write value.
REQ-023 Read and write paths SHALL be fully independent; neither SHALL stall the other.
REQ-024 s_bresp and s_rresp SHALL be 2'b00 (OKAY) for in-range accesses.
REQ-025 A write with s_wstrb all zero SHALL leave the register unchanged but still pulse wr_pulse_o and respond OKAY.

Reset
REQ-026 While rst is high on a clock edge, the block SHALL reset as follows:
- all registers and regs_o to 0;
- wr_pulse_o to 0;
- s_bvalid and s_rvalid to 0, s_bresp and s_rresp to 0, s_rdata to 0;
- holding registers cleared;
- FSMs to W_IDLE / R_IDLE.
REQ-027 Reset asserted mid-transaction SHALL discard the pending AW/W/AR without issuing a response.
REQ-028 During reset, s_awready, s_wready and s_arready SHALL be 0.

Configuration
REQ-029 With macro AXI_LITE_REGFILE_DECERR_EN defined, out-of-range writes SHALL be dropped with s_bresp = 2'b11 (DECERR), and out-of-range reads SHALL return s_rdata = 0 with s_rresp = 2'b11.
REQ-030 Without AXI_LITE_REGFILE_DECERR_EN, out-of-range writes SHALL be dropped and out-of-range reads SHALL return 0, both with response OKAY.

Verification
REQ-031 The bench SHALL run: AW 0x04 and W 0xDEADBEEF with strb 0xF in the same cycle -> next cycle reg1 = 0xDEADBEEF, wr_pulse_o = 0x02, bvalid = 1, bresp = 00.
REQ-032 The bench SHALL run: W 0x11223344 with strb 0x5, then AW 0x08 three cycles later, with reg2 = 0xAABBCCDD beforehand -> reg2 = 0xAA22CC44, and wready = 0 between the two handshakes.
REQ-033 The bench SHALL run: AR 0x04 with rready held low for 4 cycles -> rvalid = 1 and rdata = 0xDEADBEEF stable throughout, and arready = 0 until the R handshake.
REQ-034 The bench SHALL run: a write to 0x0C (0x5) and a read of 0x0C completing on the same edge, with reg3 = 0x0 beforehand -> rdata = 0x0, then reg3 = 0x5.
REQ-035 The bench SHALL run: a write and a read to 0x20 with NUM_REGS = 8 -> with the macro, bresp = rresp = 11 and rdata = 0; without it, both = 00; in both cases no register changes.
REQ-036 The bench SHALL run: rst asserted with AW latched but W pending -> no bvalid is issued, and after reset a fresh write to 0x00 responds normally.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers, also driven out flat on regs_o.
// Define AXI_LITE_REGFILE_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi_lite_regfile #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [ADDR_WIDTH-1:0]            s_awaddr,
    input  logic                             s_awvalid,
    output logic                             s_awready,

    input  logic [DATA_WIDTH-1:0]            s_wdata,
    input  logic [DATA_WIDTH/8-1:0]          s_wstrb,
    input  logic                             s_wvalid,
    output logic                             s_wready,

    output logic [1:0]                       s_bresp,
    output logic                             s_bvalid,
    input  logic                             s_bready,

    input  logic [ADDR_WIDTH-1:0]            s_araddr,
    input  logic                             s_arvalid,
    output logic                             s_arready,

    output logic [DATA_WIDTH-1:0]            s_rdata,
    output logic [1:0]                       s_rresp,
    output logic                             s_rvalid,
    input  logic                             s_rready,

    output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_o,
    output logic [NUM_REGS-1:0]              wr_pulse_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
`ifdef AXI_LITE_REGFILE_DECERR_EN
    localparam logic [1:0] RESP_OOR    = 2'b11;
`else
    localparam logic [1:0] RESP_OOR    = RESP_OKAY;
`endif

    typedef enum logic [1:0] {
        W_IDLE,
        W_GOT_AW,
        W_GOT_W,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Register storage and write-side pulses
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

    // Write channel state
    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [1:0]            bresp_q, bresp_d;

    // Read channel state
    r_state_e              r_state_q, r_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_commit;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_index, rd_index;
    logic [DATA_WIDTH-1:0] wr_data, rd_word;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  wr_in_range, rd_in_range;

    // Ready signals are forced low while reset is held.
    assign s_awready = !rst && ((w_state_q == W_IDLE) || (w_state_q == W_GOT_W));
    assign s_wready  = !rst && ((w_state_q == W_IDLE) || (w_state_q == W_GOT_AW));
    assign s_arready = !rst && (r_state_q == R_IDLE);

    assign s_bvalid  = (w_state_q == W_RESP);
    assign s_bresp   = bresp_q;
    assign s_rvalid  = (r_state_q == R_DATA);
    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;

    assign wr_pulse_o = wr_pulse_q;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
        assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    // The half already latched comes from the holding register, the other from the bus.
    assign wr_addr = (w_state_q == W_GOT_AW) ? awaddr_q : s_awaddr;
    assign wr_data = (w_state_q == W_GOT_W) ? wdata_q : s_wdata;
    assign wr_strb = (w_state_q == W_GOT_W) ? wstrb_q : s_wstrb;

    assign wr_index    = wr_addr >> ADDR_LSB;
    assign wr_in_range = wr_index < ADDR_WIDTH'(NUM_REGS);
    assign rd_index    = s_araddr >> ADDR_LSB;
    assign rd_in_range = rd_index < ADDR_WIDTH'(NUM_REGS);

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        wr_commit = 1'b0;

        if (aw_hs) begin
            awaddr_d = s_awaddr;
        end
        if (w_hs) begin
            wdata_d = s_wdata;
            wstrb_d = s_wstrb;
        end

        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                end else if (aw_hs) begin
                    w_state_d = W_GOT_AW;
                end else if (w_hs) begin
                    w_state_d = W_GOT_W;
                end
            end
            W_GOT_AW: begin
                if (w_hs) begin
                    wr_commit = 1'b1;
                end
            end
            W_GOT_W: begin
                if (aw_hs) begin
                    wr_commit = 1'b1;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    w_state_d = W_IDLE;
                    awaddr_d  = '0;
                    wdata_d   = '0;
                    wstrb_d   = '0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        if (wr_commit) begin
            w_state_d = W_RESP;
            bresp_d   = wr_in_range ? RESP_OKAY : RESP_OOR;
        end
    end

    // Byte-lane merge; an all-zero strobe still pulses the register.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (wr_commit && wr_in_range) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_index == ADDR_WIDTH'(i)) begin
                    wr_pulse_d[i] = 1'b1;
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (wr_strb[b]) begin
                            regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Reads sample regs_q, so a same-edge write is seen only by later reads.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_index == ADDR_WIDTH'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = rd_in_range ? rd_word : '0;
                    rresp_d   = rd_in_range ? RESP_OKAY : RESP_OOR;
                end
            end
            R_DATA: begin
                if (s_rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            wr_pulse_q <= '0;
            w_state_q  <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            w_state_q  <= w_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed table, corner sequences, randomized traffic.
module tb_axi_lite_regfile;

    localparam int NR = 8;

`ifdef AXI_LITE_REGFILE_DECERR_EN
    localparam logic [1:0] OOR_RESP = 2'b11;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic        clk, rst;
    logic [31:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic [255:0] regs_o;
    logic [7:0]  wr_pulse_o;

    axi_lite_regfile #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .regs_o    (regs_o),
        .wr_pulse_o(wr_pulse_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model_regs [NR];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_pulse;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = model_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
    endtask

    // Word index is the byte address divided by four; anything past NR is dropped.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [7:0] pulse,
                               output logic [1:0] resp);
        int idx;
        logic [31:0] mask;
        idx   = int'(addr / 4);
        pulse = '0;
        resp  = OOR_RESP;
        if (idx < NR) begin
            mask = '0;
            for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
            model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
            pulse = 8'(1 << idx);
            resp  = 2'b00;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr / 4);
        if (idx < NR) begin
            data = model_regs[idx];
            resp = 2'b00;
        end else begin
            data = '0;
            resp = OOR_RESP;
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output logic [7:0] pulse, output bit ok);
        int cyc;
        bit aw_done, w_done, aw_fire, w_fire;
        cyc = 0; aw_done = 0; w_done = 0;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_wvalid  = !w_done && (cyc >= w_dly);
            aw_fire   = s_awvalid && s_awready;
            w_fire    = s_wvalid && s_wready;
            tick();
            cyc++;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
        end
        s_awvalid = 0; s_wvalid = 0;
        ok    = aw_done && w_done && s_bvalid;
        resp  = s_bresp;
        pulse = wr_pulse_o;
        s_bready = 1;
        tick();
        s_bready = 0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        int cyc;
        cyc = 0;
        s_araddr = addr; s_arvalid = 1;
        while (!s_arready && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        s_arvalid = 0;
        ok   = s_rvalid;
        data = s_rdata;
        resp = s_rresp;
        s_rready = 1;
        tick();
        s_rready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] rd, exp_d;
        logic [1:0]  rsp, exp_r;
        logic [7:0]  pls, exp_p;
        bit ok;

        vecs.push_back('{1, 32'h00, 32'h12345678, 4'hF, 32'h0, 2'b00, 8'h01});
        vecs.push_back('{0, 32'h00, 32'h0, 4'h0, 32'h12345678, 2'b00, 8'h00});
        vecs.push_back('{1, 32'h01, 32'hFFFFFFFF, 4'h1, 32'h0, 2'b00, 8'h01});
        vecs.push_back('{0, 32'h03, 32'h0, 4'h0, 32'h123456FF, 2'b00, 8'h00});
        vecs.push_back('{1, 32'h1C, 32'hCAFEF00D, 4'h0, 32'h0, 2'b00, 8'h80});
        vecs.push_back('{0, 32'h1C, 32'h0, 4'h0, 32'h00000000, 2'b00, 8'h00});
        vecs.push_back('{1, 32'h1C, 32'hCAFEF00D, 4'hC, 32'h0, 2'b00, 8'h80});
        vecs.push_back('{0, 32'h1D, 32'h0, 4'h0, 32'hCAFE0000, 2'b00, 8'h00});
        vecs.push_back('{0, 32'h24, 32'h0, 4'h0, 32'h00000000, OOR_RESP, 8'h00});
        vecs.push_back('{1, 32'h10, 32'hA5A5A5A5, 4'h6, 32'h0, 2'b00, 8'h10});
        vecs.push_back('{0, 32'h10, 32'h0, 4'h0, 32'h00A5A500, 2'b00, 8'h00});

        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
        s_araddr = '0; s_arvalid = 0; s_rready = 0;

        // Reset and reset state
        rst = 1;
        tick();
        tick();
        chk("rst_awready", 256'(s_awready), 256'(0));
        chk("rst_wready", 256'(s_wready), 256'(0));
        chk("rst_arready", 256'(s_arready), 256'(0));
        rst = 0;
        tick();
        model_reset();
        chk("reset_regs", regs_o, 256'(0));
        chk("reset_pulse", 256'(wr_pulse_o), 256'(0));
        chk("reset_bvalid", 256'(s_bvalid), 256'(0));
        chk("reset_rvalid", 256'(s_rvalid), 256'(0));
        chk("reset_rdata", 256'(s_rdata), 256'(0));
        chk("reset_resps", 256'({s_bresp, s_rresp}), 256'(0));
        chk("reset_awready", 256'(s_awready), 256'(1));

        // Directed vector table
        foreach (vecs[k]) begin
            if (vecs[k].is_wr) begin
                axi_write(vecs[k].addr, vecs[k].data, vecs[k].strb, 0, 0, rsp, pls, ok);
                model_write(vecs[k].addr, vecs[k].data, vecs[k].strb, exp_p, exp_r);
                chk($sformatf("tbl%0d_bvalid", k), 256'(ok), 256'(1));
                chk($sformatf("tbl%0d_bresp", k), 256'(rsp), 256'(vecs[k].exp_resp));
                chk($sformatf("tbl%0d_pulse", k), 256'(pls), 256'(vecs[k].exp_pulse));
                chk($sformatf("tbl%0d_regs", k), regs_o, model_flat());
            end else begin
                axi_read(vecs[k].addr, rd, rsp, ok);
                chk($sformatf("tbl%0d_rvalid", k), 256'(ok), 256'(1));
                chk($sformatf("tbl%0d_rdata", k), 256'(rd), 256'(vecs[k].exp_rdata));
                chk($sformatf("tbl%0d_rresp", k), 256'(rsp), 256'(vecs[k].exp_resp));
            end
        end

        // AW and W in the same cycle
        s_awaddr = 32'h04; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0;
        model_write(32'h04, 32'hDEADBEEF, 4'hF, exp_p, exp_r);
        chk("same_cycle_reg1", 256'(regs_o[63:32]), 256'(32'hDEADBEEF));
        chk("same_cycle_pulse", 256'(wr_pulse_o), 256'(8'h02));
        chk("same_cycle_bvalid", 256'(s_bvalid), 256'(1));
        chk("same_cycle_bresp", 256'(s_bresp), 256'(0));
        s_bready = 1;
        tick();
        s_bready = 0;
        chk("same_cycle_pulse_drop", 256'(wr_pulse_o), 256'(0));

        // W first, AW three cycles later
        axi_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, rsp, pls, ok);
        model_write(32'h08, 32'hAABBCCDD, 4'hF, exp_p, exp_r);
        s_wdata = 32'h11223344; s_wstrb = 4'h5; s_wvalid = 1;
        tick();
        s_wvalid = 0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("w_first_wready_c%0d", c), 256'(s_wready), 256'(0));
            chk($sformatf("w_first_bvalid_c%0d", c), 256'(s_bvalid), 256'(0));
            if (c < 2) tick();
        end
        s_awaddr = 32'h08; s_awvalid = 1;
        tick();
        s_awvalid = 0;
        model_write(32'h08, 32'h11223344, 4'h5, exp_p, exp_r);
        chk("w_first_wready_resp", 256'(s_wready), 256'(0));
        chk("w_first_bvalid", 256'(s_bvalid), 256'(1));
        chk("w_first_reg2", 256'(regs_o[95:64]), 256'(32'hAA22CC44));
        s_bready = 1;
        tick();
        s_bready = 0;

        // Read held off by rready
        s_araddr = 32'h04; s_arvalid = 1;
        tick();
        s_arvalid = 0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rhold_rvalid_c%0d", c), 256'(s_rvalid), 256'(1));
            chk($sformatf("rhold_rdata_c%0d", c), 256'(s_rdata), 256'(32'hDEADBEEF));
            chk($sformatf("rhold_arready_c%0d", c), 256'(s_arready), 256'(0));
            tick();
        end
        s_rready = 1;
        tick();
        s_rready = 0;
        chk("rhold_rvalid_done", 256'(s_rvalid), 256'(0));
        chk("rhold_arready_done", 256'(s_arready), 256'(1));

        // Read and write to the same register on the same edge
        s_awaddr = 32'h0C; s_wdata = 32'h5; s_wstrb = 4'hF; s_araddr = 32'h0C;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1;
        tick();
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        model_write(32'h0C, 32'h5, 4'hF, exp_p, exp_r);
        chk("rw_same_rvalid", 256'(s_rvalid), 256'(1));
        chk("rw_same_rdata", 256'(s_rdata), 256'(0));
        chk("rw_same_bvalid", 256'(s_bvalid), 256'(1));
        chk("rw_same_reg3", 256'(regs_o[127:96]), 256'(32'h5));
        s_bready = 1; s_rready = 1;
        tick();
        s_bready = 0; s_rready = 0;

        // Out-of-range write and read
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, rsp, pls, ok);
        chk("oor_bvalid", 256'(ok), 256'(1));
        chk("oor_bresp", 256'(rsp), 256'(OOR_RESP));
        chk("oor_pulse", 256'(pls), 256'(0));
        chk("oor_regs", regs_o, model_flat());
        axi_read(32'h20, rd, rsp, ok);
        chk("oor_rvalid", 256'(ok), 256'(1));
        chk("oor_rdata", 256'(rd), 256'(0));
        chk("oor_rresp", 256'(rsp), 256'(OOR_RESP));

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            a = (32'($urandom_range(0, 11)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), rsp, pls, ok);
                model_write(a, d, s, exp_p, exp_r);
                chk($sformatf("rnd%0d_wr_ok", n), 256'(ok), 256'(1));
                chk($sformatf("rnd%0d_bresp", n), 256'(rsp), 256'(exp_r));
                chk($sformatf("rnd%0d_pulse", n), 256'(pls), 256'(exp_p));
                chk($sformatf("rnd%0d_regs", n), regs_o, model_flat());
            end else begin
                axi_read(a, rd, rsp, ok);
                model_read(a, exp_d, exp_r);
                chk($sformatf("rnd%0d_rd_ok", n), 256'(ok), 256'(1));
                chk($sformatf("rnd%0d_rdata", n), 256'(rd), 256'(exp_d));
                chk($sformatf("rnd%0d_rresp", n), 256'(rsp), 256'(exp_r));
            end
        end

        // Reset with AW latched and W still pending
        s_awaddr = 32'h00; s_awvalid = 1;
        tick();
        s_awvalid = 0;
        chk("midrst_awready_latched", 256'(s_awready), 256'(0));
        rst = 1;
        tick();
        chk("midrst_awready", 256'(s_awready), 256'(0));
        chk("midrst_wready", 256'(s_wready), 256'(0));
        chk("midrst_arready", 256'(s_arready), 256'(0));
        chk("midrst_bvalid", 256'(s_bvalid), 256'(0));
        rst = 0;
        tick();
        model_reset();
        chk("midrst_regs", regs_o, 256'(0));
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("midrst_no_b_c%0d", c), 256'(s_bvalid), 256'(0));
            chk($sformatf("midrst_wready_c%0d", c), 256'(s_wready), 256'(1));
            tick();
        end
        axi_write(32'h00, 32'h600DF00D, 4'hF, 0, 0, rsp, pls, ok);
        model_write(32'h00, 32'h600DF00D, 4'hF, exp_p, exp_r);
        chk("post_rst_bvalid", 256'(ok), 256'(1));
        chk("post_rst_bresp", 256'(rsp), 256'(0));
        chk("post_rst_pulse", 256'(pls), 256'(exp_p));
        chk("post_rst_regs", regs_o, model_flat());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
